l1_moesi_cache: RTL and testbench
=================================

# l1_moesi_cache

Parametrised single-core L1 data cache: direct-mapped tag/state/data array, CPU-side MOESI controller FSM and bus snooper in one block. It sits between one CPU core and the shared snooping bus, replacing the fixed-width L1 top. Compared with that block it adds configurable geometry and data width, dirty-victim write-back on eviction, and upgrade-race recovery, where a pending BUS_UPGR becomes BUS_RDX if a snoop invalidates the line.

## Interface
- ADDR_BITS, 6, line address width (byte offset already stripped)
- INDEX_BITS, 2, set index width; 2^INDEX_BITS lines; TAG_BITS = ADDR_BITS-INDEX_BITS
- DATA_BITS, 8, line data width
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_valid  in  1  CPU request valid
- cpu_command  in  1  0 = load, 1 = store
- cpu_addr  in  ADDR_BITS  request line address
- cpu_write_data  in  DATA_BITS  store data
- cpu_ready  out  1  block can accept a request
- cpu_read_valid  out  1  one-cycle load-data strobe
- cpu_read_data  out  DATA_BITS  load data
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus accepts request
- bus_req_addr  out  ADDR_BITS  request address
- bus_req  out  2  BUS_RD=0, BUS_RDX=1, BUS_UPGR=2, BUS_WB=3
- bus_req_data  out  DATA_BITS  write-back data; 0 otherwise
- bus_resp_valid  in  1  fill data valid
- bus_resp_data  in  DATA_BITS  fill data
- bus_resp_shared  in  1  another cache holds the line
- snoop_valid  in  1  snooped transaction, one-cycle pulse
- snoop_addr  in  ADDR_BITS  snooped address
- snoop_req  in  2  snooped bus_req encoding
- snoop_shared  out  1  registered: line present here
- snoop_data  out  DATA_BITS  registered: line data on hit, else 0

## Operation
- Line state: I=0, S=1, E=2, O=3, M=4. Hit = state≠I and tag match at index.
- Controller FSM: IDLE, WB, UPGR, FILL_REQ, FILL_WAIT, RESP. cpu_ready=1 only in IDLE (and not in reset).
- IDLE, request accepted (cpu_valid&cpu_ready), lookup combinational in the same cycle:
  - load hit: go to RESP, no state change
  - store hit E/M: write data, state→M, stay IDLE
  - store hit S/O: go to UPGR
  - miss with victim M/O: go to WB; victim I/S/E: go to FILL_REQ. Clean victims are dropped silently.
- WB: bus_req=BUS_WB, victim address and current victim data. On handshake: victim→I, go to FILL_REQ. If a snoop invalidates the victim while waiting, abort the WB (drop valid) and go to FILL_REQ.
- UPGR: bus_req=BUS_UPGR. On handshake: write data, state→M, go to IDLE. Line state is re-checked each cycle; if it is no longer S/O, go to FILL_REQ as a store miss.
- FILL_REQ: BUS_RD for a load, BUS_RDX for a store. On handshake go to FILL_WAIT.
- FILL_WAIT: on bus_resp_valid, write tag and data, then:
  - load: data = bus_resp_data; state = shared?S:E; go to RESP
  - store: data = cpu_write_data; state M; go to IDLE
- RESP: cpu_read_valid=1 for one cycle with line data; go to IDLE.
- Snooper, on a snoop_valid hit:
  - BUS_RD: M→O, E→S, O/S unchanged; shared=1, data=line
  - BUS_RDX / BUS_UPGR: →I; shared=1, data=line
  - BUS_WB: no change; shared=0, data=0
  - miss: shared=0, data=0
- Collision: controller and snooper write the same index in one cycle → controller write wins, snoop update dropped. The snoop response still reflects the pre-edge line.

## Timing
- Reset (any cycle, mid-operation included): all lines I, tag 0, data 0; FSM→IDLE; all outputs 0, bus_req=BUS_RD; dirty data discarded. cpu_ready=1 first cycle after reset deasserts.
- Load hit latency: accept edge + 1 → cpu_read_valid.
- Store hit E/M: completes at the accept edge; cpu_ready stays 1.
- bus_req_valid and all bus_req_* fields are held stable until bus_req_ready, except for the WB abort and the UPGR→RDX conversion, which may change them before handshake.
- Load-miss read data: the cycle after bus_resp_valid.
- Snoop response is valid the cycle after snoop_valid and held 1 cycle, then returns to 0. Snoop state update at the snoop_valid edge.
- cpu_* inputs are sampled only at the accept edge and held internally.

## Test plan
- Load miss 0x05, resp 0xA5, shared=0 → BUS_RD 0x05; read_valid 0xA5 the cycle after resp; line E. Reload 0x05 → read_valid 0xA5 one cycle later, no bus request.
- Store 0x3C to 0x05 (E) → no bus, state M. Then load 0x09 → BUS_WB addr 0x05 data 0x3C, then BUS_RD 0x09.
- Line 0x05 M, snoop BUS_RD 0x05 → next cycle shared=1, data 0x3C; state O. Store to 0x05 → BUS_UPGR, then state M.
- Line 0x05 S, store 0x77 with bus_req_ready=0; snoop BUS_RDX 0x05 → request switches to BUS_RDX 0x05; after resp, line M 0x77, no read_valid.
- Snoop BUS_RD 0x22 (miss) → shared=0, data=0. Reset asserted in FILL_WAIT → outputs 0; load 0x05 then misses (BUS_RD).

Source files
------------

// File: rtl/l1_moesi_cache.sv
// l1_moesi_cache: single-core direct-mapped L1 data cache with a MOESI
// controller FSM on the CPU side and a bus snooper, sharing one line array.
//
// Handshakes: a CPU request transfers on a cycle where cpu_valid && cpu_ready.
// A bus request transfers on a cycle where bus_req_valid && bus_req_ready.
// Once raised, bus_req_valid and every bus_req_* field stay stable until that
// transfer, with two exceptions: an aborted write-back (victim invalidated by
// a snoop) and an upgrade that turns into BUS_RDX after losing its line.
module l1_moesi_cache #(
  parameter int ADDR_BITS  = 6,
  parameter int INDEX_BITS = 2,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_valid,
  input  logic                 cpu_command,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [DATA_BITS-1:0] cpu_write_data,
  output logic                 cpu_ready,
  output logic                 cpu_read_valid,
  output logic [DATA_BITS-1:0] cpu_read_data,
  output logic                 bus_req_valid,
  input  logic                 bus_req_ready,
  output logic [ADDR_BITS-1:0] bus_req_addr,
  output logic [1:0]           bus_req,
  output logic [DATA_BITS-1:0] bus_req_data,
  input  logic                 bus_resp_valid,
  input  logic [DATA_BITS-1:0] bus_resp_data,
  input  logic                 bus_resp_shared,
  input  logic                 snoop_valid,
  input  logic [ADDR_BITS-1:0] snoop_addr,
  input  logic [1:0]           snoop_req,
  output logic                 snoop_shared,
  output logic [DATA_BITS-1:0] snoop_data
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  // Line states
  localparam logic [2:0] L_I = 3'd0;
  localparam logic [2:0] L_S = 3'd1;
  localparam logic [2:0] L_E = 3'd2;
  localparam logic [2:0] L_O = 3'd3;
  localparam logic [2:0] L_M = 3'd4;

  // Bus request encodings
  localparam logic [1:0] BUS_RD   = 2'd0;
  localparam logic [1:0] BUS_RDX  = 2'd1;
  localparam logic [1:0] BUS_UPGR = 2'd2;
  localparam logic [1:0] BUS_WB   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WB        = 3'd1,
    ST_UPGR      = 3'd2,
    ST_FILL_REQ  = 3'd3,
    ST_FILL_WAIT = 3'd4,
    ST_RESP      = 3'd5
  } ctrl_state_e;

  ctrl_state_e state_q, state_d;

  // Request held from the accept edge
  logic                 cmd_q, cmd_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;

  // Line array
  logic [LINES-1:0][2:0]           line_state_q, line_state_d;
  logic [LINES-1:0][TAG_BITS-1:0]  line_tag_q, line_tag_d;
  logic [LINES-1:0][DATA_BITS-1:0] line_data_q, line_data_d;

  // Registered snoop response
  logic                 snoop_shared_q, snoop_shared_d;
  logic [DATA_BITS-1:0] snoop_data_q, snoop_data_d;

  // Controller line-write port (wins over the snooper on the same index)
  logic                  ctrl_we;
  logic [INDEX_BITS-1:0] ctrl_idx;
  logic [TAG_BITS-1:0]   ctrl_tag;
  logic [DATA_BITS-1:0]  ctrl_data;
  logic [2:0]            ctrl_state;

  // Address decode for the incoming request, the held request and the snoop
  logic [INDEX_BITS-1:0] in_idx, req_idx, s_idx;
  logic [TAG_BITS-1:0]   in_tag, req_tag, s_tag;
  logic                  in_hit, req_hit, s_hit;
  logic [2:0]            in_st, req_st, s_st;

  assign in_idx  = cpu_addr[INDEX_BITS-1:0];
  assign in_tag  = cpu_addr[ADDR_BITS-1:INDEX_BITS];
  assign req_idx = addr_q[INDEX_BITS-1:0];
  assign req_tag = addr_q[ADDR_BITS-1:INDEX_BITS];
  assign s_idx   = snoop_addr[INDEX_BITS-1:0];
  assign s_tag   = snoop_addr[ADDR_BITS-1:INDEX_BITS];

  assign in_st   = line_state_q[in_idx];
  assign req_st  = line_state_q[req_idx];
  assign s_st    = line_state_q[s_idx];
  assign in_hit  = (in_st != L_I) && (line_tag_q[in_idx] == in_tag);
  assign req_hit = (req_st != L_I) && (line_tag_q[req_idx] == req_tag);
  assign s_hit   = (s_st != L_I) && (line_tag_q[s_idx] == s_tag);

  assign snoop_shared = snoop_shared_q;
  assign snoop_data   = snoop_data_q;

  // Controller next state, CPU/bus outputs and controller line writes
  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    ctrl_we        = 1'b0;
    ctrl_idx       = req_idx;
    ctrl_tag       = req_tag;
    ctrl_data      = line_data_q[req_idx];
    ctrl_state     = req_st;
    cpu_ready      = 1'b0;
    cpu_read_valid = 1'b0;
    cpu_read_data  = '0;
    bus_req_valid  = 1'b0;
    bus_req_addr   = '0;
    bus_req        = BUS_RD;
    bus_req_data   = '0;

    case (state_q)
      ST_IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_valid) begin
          cmd_d   = cpu_command;
          addr_d  = cpu_addr;
          wdata_d = cpu_write_data;
          if (in_hit && !cpu_command) begin
            state_d = ST_RESP;
          end else if (in_hit && (in_st == L_E || in_st == L_M)) begin
            // Exclusive store hit completes silently at the accept edge
            ctrl_we    = 1'b1;
            ctrl_idx   = in_idx;
            ctrl_tag   = in_tag;
            ctrl_data  = cpu_write_data;
            ctrl_state = L_M;
          end else if (in_hit) begin
            state_d = ST_UPGR;
          end else if (in_st == L_M || in_st == L_O) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FILL_REQ;
          end
        end
      end

      ST_WB: begin
        if (req_st == L_M || req_st == L_O) begin
          bus_req_valid = 1'b1;
          bus_req       = BUS_WB;
          bus_req_addr  = {line_tag_q[req_idx], req_idx};
          bus_req_data  = line_data_q[req_idx];
          if (bus_req_ready) begin
            ctrl_we    = 1'b1;
            ctrl_tag   = line_tag_q[req_idx];
            ctrl_state = L_I;
            state_d    = ST_FILL_REQ;
          end
        end else begin
          // A snoop took the dirty victim away; nothing left to write back
          state_d = ST_FILL_REQ;
        end
      end

      ST_UPGR: begin
        if (req_hit && (req_st == L_S || req_st == L_O)) begin
          bus_req_valid = 1'b1;
          bus_req       = BUS_UPGR;
          bus_req_addr  = addr_q;
          if (bus_req_ready) begin
            ctrl_we    = 1'b1;
            ctrl_data  = wdata_q;
            ctrl_state = L_M;
            state_d    = ST_IDLE;
          end
        end else begin
          // Line lost to a snoop: retry as a full store miss (BUS_RDX)
          state_d = ST_FILL_REQ;
        end
      end

      ST_FILL_REQ: begin
        bus_req_valid = 1'b1;
        bus_req       = cmd_q ? BUS_RDX : BUS_RD;
        bus_req_addr  = addr_q;
        if (bus_req_ready) begin
          state_d = ST_FILL_WAIT;
        end
      end

      ST_FILL_WAIT: begin
        if (bus_resp_valid) begin
          ctrl_we  = 1'b1;
          ctrl_tag = req_tag;
          if (cmd_q) begin
            ctrl_data  = wdata_q;
            ctrl_state = L_M;
            state_d    = ST_IDLE;
          end else begin
            ctrl_data  = bus_resp_data;
            ctrl_state = bus_resp_shared ? L_S : L_E;
            state_d    = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        cpu_read_valid = 1'b1;
        cpu_read_data  = line_data_q[req_idx];
        state_d        = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Reset forces every output low and blocks all line writes
    if (reset) begin
      ctrl_we        = 1'b0;
      cpu_ready      = 1'b0;
      cpu_read_valid = 1'b0;
      cpu_read_data  = '0;
      bus_req_valid  = 1'b0;
      bus_req_addr   = '0;
      bus_req        = BUS_RD;
      bus_req_data   = '0;
    end
  end

  // Snoop state update and response, then controller write overriding it
  always_comb begin
    line_state_d   = line_state_q;
    line_tag_d     = line_tag_q;
    line_data_d    = line_data_q;
    snoop_shared_d = 1'b0;
    snoop_data_d   = '0;

    if (snoop_valid && s_hit) begin
      case (snoop_req)
        BUS_RD: begin
          snoop_shared_d = 1'b1;
          snoop_data_d   = line_data_q[s_idx];
          if (s_st == L_M) begin
            line_state_d[s_idx] = L_O;
          end else if (s_st == L_E) begin
            line_state_d[s_idx] = L_S;
          end
        end
        BUS_RDX, BUS_UPGR: begin
          snoop_shared_d      = 1'b1;
          snoop_data_d        = line_data_q[s_idx];
          line_state_d[s_idx] = L_I;
        end
        default: begin
          // BUS_WB from another cache: no state change, no response
        end
      endcase
    end

    if (ctrl_we) begin
      line_state_d[ctrl_idx] = ctrl_state;
      line_tag_d[ctrl_idx]   = ctrl_tag;
      line_data_d[ctrl_idx]  = ctrl_data;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cmd_q          <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      line_state_q   <= '0;
      line_tag_q     <= '0;
      line_data_q    <= '0;
      snoop_shared_q <= 1'b0;
      snoop_data_q   <= '0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      line_state_q   <= line_state_d;
      line_tag_q     <= line_tag_d;
      line_data_q    <= line_data_d;
      snoop_shared_q <= snoop_shared_d;
      snoop_data_q   <= snoop_data_d;
    end
  end

endmodule

// File: tb/tb_l1_moesi_cache.sv
// tb_l1_moesi_cache: directed sequence against l1_moesi_cache with a load-data
// scoreboard (expected values queued when the load is issued).
module tb_l1_moesi_cache;
  localparam int AB = 6;
  localparam int IB = 2;
  localparam int DB = 8;

  localparam logic [1:0] RD = 2'd0, RDX = 2'd1, UPGR = 2'd2, WB = 2'd3;
  localparam logic [2:0] L_I = 3'd0, L_S = 3'd1, L_E = 3'd2, L_O = 3'd3, L_M = 3'd4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_valid = 1'b0;
  logic          cpu_command = 1'b0;
  logic [AB-1:0] cpu_addr = '0;
  logic [DB-1:0] cpu_write_data = '0;
  logic          cpu_ready;
  logic          cpu_read_valid;
  logic [DB-1:0] cpu_read_data;
  logic          bus_req_valid;
  logic          bus_req_ready = 1'b0;
  logic [AB-1:0] bus_req_addr;
  logic [1:0]    bus_req;
  logic [DB-1:0] bus_req_data;
  logic          bus_resp_valid = 1'b0;
  logic [DB-1:0] bus_resp_data = '0;
  logic          bus_resp_shared = 1'b0;
  logic          snoop_valid = 1'b0;
  logic [AB-1:0] snoop_addr = '0;
  logic [1:0]    snoop_req = 2'd0;
  logic          snoop_shared;
  logic [DB-1:0] snoop_data;

  int checks = 0;
  int errors = 0;
  logic [DB-1:0] exp_q[$];

  l1_moesi_cache #(.ADDR_BITS(AB), .INDEX_BITS(IB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_command(cpu_command), .cpu_addr(cpu_addr),
    .cpu_write_data(cpu_write_data), .cpu_ready(cpu_ready),
    .cpu_read_valid(cpu_read_valid), .cpu_read_data(cpu_read_data),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_addr(bus_req_addr), .bus_req(bus_req), .bus_req_data(bus_req_data),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
    .bus_resp_shared(bus_resp_shared),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_req(snoop_req),
    .snoop_shared(snoop_shared), .snoop_data(snoop_data)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one CPU request once the cache is ready
  task automatic cpu_req(input logic cmd, input logic [AB-1:0] addr, input logic [DB-1:0] wd);
    int n = 0;
    while (!cpu_ready && n < 50) begin
      tick();
      n++;
    end
    check("cpu_ready_wait", 32'(cpu_ready), 32'd1);
    cpu_valid      = 1'b1;
    cpu_command    = cmd;
    cpu_addr       = addr;
    cpu_write_data = wd;
    tick();
    cpu_valid      = 1'b0;
  endtask

  // Wait for a bus request, compare its fields, then accept it
  task automatic bus_hs(input string tag, input logic [1:0] req, input logic [AB-1:0] addr,
                        input logic [DB-1:0] d);
    int n = 0;
    while (!bus_req_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(bus_req_valid), 32'd1);
    check({tag, "_req"}, 32'(bus_req), 32'(req));
    check({tag, "_addr"}, 32'(bus_req_addr), 32'(addr));
    check({tag, "_data"}, 32'(bus_req_data), 32'(d));
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
  endtask

  task automatic bus_resp(input logic [DB-1:0] d, input logic sh);
    bus_resp_valid  = 1'b1;
    bus_resp_data   = d;
    bus_resp_shared = sh;
    tick();
    bus_resp_valid  = 1'b0;
    bus_resp_data   = '0;
    bus_resp_shared = 1'b0;
  endtask

  // One-cycle snoop pulse; response checked for one cycle, then back to 0
  task automatic snoop(input string tag, input logic [AB-1:0] a, input logic [1:0] r,
                       input logic exp_sh, input logic [DB-1:0] exp_d);
    snoop_valid = 1'b1;
    snoop_addr  = a;
    snoop_req   = r;
    tick();
    snoop_valid = 1'b0;
    check({tag, "_shared"}, 32'(snoop_shared), 32'(exp_sh));
    check({tag, "_data"}, 32'(snoop_data), 32'(exp_d));
    tick();
    check({tag, "_shared_clr"}, 32'(snoop_shared), 32'd0);
    check({tag, "_data_clr"}, 32'(snoop_data), 32'd0);
  endtask

  // Scoreboard: every load-data strobe must match the oldest expected value
  always @(negedge clk) begin
    if (!reset && cpu_read_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", 32'(cpu_read_valid), 32'd0);
      end else begin
        check("read_data", 32'(cpu_read_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset
    repeat (3) tick();
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_bus_valid", 32'(bus_req_valid), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'(RD));
    check("rst_snoop_shared", 32'(snoop_shared), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(cpu_ready), 32'd1);

    // Load miss 0x05, exclusive fill
    exp_q.push_back(8'hA5);
    cpu_req(1'b0, 6'h05, 8'h00);
    bus_hs("rd05", RD, 6'h05, 8'h00);
    bus_resp(8'hA5, 1'b0);
    check("miss_read_valid", 32'(cpu_read_valid), 32'd1);
    check("line05_E", 32'(dut.line_state_q[1]), 32'(L_E));

    // Reload hits, data one cycle after accept, no bus traffic
    exp_q.push_back(8'hA5);
    cpu_req(1'b0, 6'h05, 8'h00);
    check("hit_read_valid", 32'(cpu_read_valid), 32'd1);
    check("hit_no_bus", 32'(bus_req_valid), 32'd0);

    // Store hit on E: silent, M
    cpu_req(1'b1, 6'h05, 8'h3C);
    check("st_hit_ready", 32'(cpu_ready), 32'd1);
    check("st_hit_no_bus", 32'(bus_req_valid), 32'd0);
    check("line05_M", 32'(dut.line_state_q[1]), 32'(L_M));
    check("line05_data", 32'(dut.line_data_q[1]), 32'h3C);

    // Conflicting load 0x09 writes back dirty victim first
    exp_q.push_back(8'h99);
    cpu_req(1'b0, 6'h09, 8'h00);
    bus_hs("wb05", WB, 6'h05, 8'h3C);
    bus_hs("rd09", RD, 6'h09, 8'h00);
    bus_resp(8'h99, 1'b1);
    check("rd09_read_valid", 32'(cpu_read_valid), 32'd1);
    check("line09_S", 32'(dut.line_state_q[1]), 32'(L_S));

    // Store miss 0x05 over a clean victim: straight to BUS_RDX, no WB
    cpu_req(1'b1, 6'h05, 8'h3C);
    bus_hs("rdx05", RDX, 6'h05, 8'h00);
    bus_resp(8'hEE, 1'b0);
    check("st_miss_ready", 32'(cpu_ready), 32'd1);
    check("st_miss_M", 32'(dut.line_state_q[1]), 32'(L_M));
    check("st_miss_data", 32'(dut.line_data_q[1]), 32'h3C);

    // Snoop BUS_RD on M line: supply data, M -> O
    snoop("snp_rd05", 6'h05, RD, 1'b1, 8'h3C);
    check("line05_O", 32'(dut.line_state_q[1]), 32'(L_O));

    // Store to O line upgrades
    cpu_req(1'b1, 6'h05, 8'h5A);
    bus_hs("upgr05", UPGR, 6'h05, 8'h00);
    check("upgr_M", 32'(dut.line_state_q[1]), 32'(L_M));
    check("upgr_data", 32'(dut.line_data_q[1]), 32'h5A);
    check("upgr_ready", 32'(cpu_ready), 32'd1);

    // Snoop BUS_RDX invalidates, then refill as shared
    snoop("snp_rdx05", 6'h05, RDX, 1'b1, 8'h5A);
    check("line05_I", 32'(dut.line_state_q[1]), 32'(L_I));
    exp_q.push_back(8'h11);
    cpu_req(1'b0, 6'h05, 8'h00);
    bus_hs("rd05_s", RD, 6'h05, 8'h00);
    bus_resp(8'h11, 1'b1);
    check("line05_S", 32'(dut.line_state_q[1]), 32'(L_S));

    // Upgrade race: pending UPGR loses the line and becomes BUS_RDX
    cpu_req(1'b1, 6'h05, 8'h77);
    check("race_upgr_valid", 32'(bus_req_valid), 32'd1);
    check("race_upgr_req", 32'(bus_req), 32'(UPGR));
    check("race_upgr_addr", 32'(bus_req_addr), 32'h05);
    snoop_valid = 1'b1;
    snoop_addr  = 6'h05;
    snoop_req   = RDX;
    tick();
    snoop_valid = 1'b0;
    check("race_snp_shared", 32'(snoop_shared), 32'd1);
    check("race_snp_data", 32'(snoop_data), 32'h11);
    check("race_line_I", 32'(dut.line_state_q[1]), 32'(L_I));
    bus_hs("race_rdx", RDX, 6'h05, 8'h00);
    bus_resp(8'h22, 1'b0);
    check("race_line_M", 32'(dut.line_state_q[1]), 32'(L_M));
    check("race_line_data", 32'(dut.line_data_q[1]), 32'h77);
    check("race_ready", 32'(cpu_ready), 32'd1);

    // Snoop miss and snoop BUS_WB hit: no response, no state change
    snoop("snp_miss22", 6'h22, RD, 1'b0, 8'h00);
    snoop("snp_wb05", 6'h05, WB, 1'b0, 8'h00);
    check("snp_wb_keep_M", 32'(dut.line_state_q[1]), 32'(L_M));

    // Reset in FILL_WAIT discards everything
    cpu_req(1'b0, 6'h0A, 8'h00);
    bus_hs("rd0a", RD, 6'h0A, 8'h00);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(cpu_ready), 32'd0);
    check("mid_rst_bus_valid", 32'(bus_req_valid), 32'd0);
    check("mid_rst_read_valid", 32'(cpu_read_valid), 32'd0);
    tick();
    check("mid_rst_line_I", 32'(dut.line_state_q[1]), 32'(L_I));
    check("mid_rst_bus_req", 32'(bus_req), 32'(RD));
    check("mid_rst_snoop", 32'(snoop_shared), 32'd0);
    reset = 1'b0;
    #1;
    check("after_rst_ready", 32'(cpu_ready), 32'd1);
    exp_q.push_back(8'h33);
    cpu_req(1'b0, 6'h05, 8'h00);
    bus_hs("rd05_after_rst", RD, 6'h05, 8'h00);
    bus_resp(8'h33, 1'b0);
    check("after_rst_read_valid", 32'(cpu_read_valid), 32'd1);
    tick();
    tick();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
